// File: rtl/common.sv
// Project-wide shared types.
package common;

    typedef logic [31:0] t_paddr;

endpackage

// File: rtl/mem_common.sv
// Memory request/response transport types shared by memory-side blocks.
package mem_common;

    import common::*;

    localparam int MEM_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [3:0]            id;
        logic                  wr;
        t_paddr                addr;
        logic [MEM_DATA_W-1:0] wdata;
    } t_mem_req;

    typedef struct packed {
        logic                  valid;
        logic [3:0]            id;
        logic                  wr;
        logic [MEM_DATA_W-1:0] data;
    } t_mem_rsp;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response delay line: valid bits are reset, payload registers are not.
module mem_rsp_pipe
    import mem_common::*;
#(
    parameter int LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [3:0]            id_i,
    input  logic                  wr_i,
    input  logic [MEM_DATA_W-1:0] data_i,
    output logic                  valid_o,
    output logic [3:0]            id_o,
    output logic                  wr_o,
    output logic [MEM_DATA_W-1:0] data_o,
    output logic                  pre_valid_o
);

    logic [LATENCY-1:0]    vld_q;
    logic [3:0]            id_q   [LATENCY];
    logic                  wr_q   [LATENCY];
    logic [MEM_DATA_W-1:0] data_q [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        id_q[0]   <= id_i;
        wr_q[0]   <= wr_i;
        data_q[0] <= data_i;
        for (int i = 1; i < LATENCY; i++) begin
            id_q[i]   <= id_q[i-1];
            wr_q[i]   <= wr_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    assign valid_o = vld_q[LATENCY-1];
    assign id_o    = id_q[LATENCY-1];
    assign wr_o    = wr_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

    // Flags an entry that reaches the output stage on the next edge.
    generate
        if (LATENCY > 1) begin : g_pre_stage
            assign pre_valid_o = vld_q[LATENCY-2];
        end else begin : g_pre_input
            assign pre_valid_o = valid_i;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one request per cycle, in-order responses after LATENCY cycles.
module mem_responder
    import common::*;
    import mem_common::*;
#(
    parameter int LATENCY   = 5,
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic     clk,
    input  logic     reset,
    input  t_mem_req req_nnn,
    output logic     rdy_nnn,
    output t_mem_rsp rsp_nnn
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = $bits(t_paddr);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  accept;
    logic                  retire;
    logic [IDX_W-1:0]      idx;
    logic [MEM_DATA_W-1:0] mem_q [MEM_WORDS];
    logic [MEM_DATA_W-1:0] load_data;
    logic                  pipe_vld;
    logic [3:0]            pipe_id;
    logic                  pipe_wr;
    logic [MEM_DATA_W-1:0] pipe_data;
    logic                  unused_addr;

    assign idx         = req_nnn.addr[IDX_W+1:2];
    assign unused_addr = ^{req_nnn.addr[ADDR_W-1:IDX_W+2], req_nnn.addr[1:0]};

    assign rdy_nnn = ~reset & (count_q < DEPTH_C);
    assign accept  = req_nnn.valid & rdy_nnn;

    // A slot is released as its response moves onto the output port, so
    // DEPTH == LATENCY never throttles a back-to-back stream.
    assign count_d = count_q + CNT_W'(accept) - CNT_W'(retire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Backing store is deliberately left out of reset so it can be preloaded.
    always @(posedge clk) begin
        if (accept && req_nnn.wr) begin
            mem_q[idx] <= req_nnn.wdata;
        end
    end

    assign load_data = req_nnn.wr ? req_nnn.wdata : mem_q[idx];

    mem_rsp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (accept),
        .id_i        (req_nnn.id),
        .wr_i        (req_nnn.wr),
        .data_i      (load_data),
        .valid_o     (pipe_vld),
        .id_o        (pipe_id),
        .wr_o        (pipe_wr),
        .data_o      (pipe_data),
        .pre_valid_o (retire)
    );

    always_comb begin
        rsp_nnn = '0;
        if (pipe_vld) begin
            rsp_nnn.valid = 1'b1;
            rsp_nnn.id    = pipe_id;
            rsp_nnn.wr    = pipe_wr;
            rsp_nnn.data  = pipe_data;
        end
    end

`ifdef ASSERT
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (DEPTH <= LATENCY);
            assert (count_q <= DEPTH_C);
            assert (!accept || (count_q < DEPTH_C));
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a queue-based reference model checked every cycle.
module tb_mem_responder;

    import common::*;
    import mem_common::*;

    localparam int LAT   = 5;
    localparam int DEP_A = 4;
    localparam int DEP_B = 5;
    localparam int WORDS = 1024;

    logic     clk   = 1'b0;
    logic     reset = 1'b1;
    t_mem_req req_a = '0;
    t_mem_req req_b = '0;
    logic     rdy_a;
    logic     rdy_b;
    t_mem_rsp rsp_a;
    t_mem_rsp rsp_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    mem_responder #(.LATENCY(LAT), .DEPTH(DEP_A), .MEM_WORDS(WORDS)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .req_nnn (req_a),
        .rdy_nnn (rdy_a),
        .rsp_nnn (rsp_a)
    );

    mem_responder #(.LATENCY(LAT), .DEPTH(DEP_B), .MEM_WORDS(WORDS)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .req_nnn (req_b),
        .rdy_nnn (rdy_b),
        .rsp_nnn (rsp_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic t_mem_rsp mk(input logic v, input logic [3:0] id, input logic wr,
                                    input logic [31:0] d);
        t_mem_rsp r;
        r.valid = v;
        r.id    = id;
        r.wr    = wr;
        r.data  = d;
        return r;
    endfunction

    // Reference model: every accepted request is due on its port exactly LAT
    // cycles after the cycle it was presented in, and holds a slot from the
    // cycle after acceptance until its response is showing.
    typedef struct {
        int          k;
        int          due;
        logic [3:0]  id;
        logic        wr;
        logic [31:0] data;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] mem_m [2][WORDS];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            t_mem_req rq;
            logic     rd;
            t_mem_rsp rs;
            t_mem_rsp ex;
            int       slots;
            logic     exr;
            ent_t     e;
            int       wi;
            rq = (k == 0) ? req_a : req_b;
            rd = (k == 0) ? rdy_a : rdy_b;
            rs = (k == 0) ? rsp_a : rsp_b;
            if (reset) pend.delete();
            slots = 0;
            ex    = '0;
            foreach (pend[i]) begin
                if (pend[i].k == k) begin
                    if (pend[i].due > cyc) slots++;
                    if (pend[i].due == cyc) ex = mk(1'b1, pend[i].id, pend[i].wr, pend[i].data);
                end
            end
            exr = !reset && (slots < ((k == 0) ? DEP_A : DEP_B));
            chk((k == 0) ? "rdy_a" : "rdy_b", 64'(rd), 64'(exr));
            chk((k == 0) ? "rsp_a" : "rsp_b", 64'(rs), 64'(ex));
            if (k == 0) chk("count_a", 64'(dut_a.count_q), 64'(slots));
            if (exr && rq.valid) begin
                wi = int'(rq.addr) / 4 % WORDS;
                if (rq.wr) mem_m[k][wi] = rq.wdata;
                e.k    = k;
                e.due  = cyc + LAT;
                e.id   = rq.id;
                e.wr   = rq.wr;
                e.data = rq.wr ? rq.wdata : mem_m[k][wi];
                pend.push_back(e);
            end
        end
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due <= cyc) pend.delete(i);
        end
    end

    task automatic send(input int k, input logic [3:0] id, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
        t_mem_req r;
        logic     ok;
        r.valid = 1'b1;
        r.id    = id;
        r.wr    = wr;
        r.addr  = addr;
        r.wdata = wd;
        if (k == 0) req_a = r; else req_b = r;
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = (k == 0) ? rdy_a : rdy_b;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted id=%0d", id);
        end
    endtask

    task automatic idle(input int k);
        if (k == 0) req_a = '0; else req_b = '0;
    endtask

    // Waits until the negedge sample point of cycle t.
    task automatic at_cycle(input int t);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < t && g < 500);
        if (cyc != t) begin
            checks++;
            errors++;
            $display("FAIL at_cycle actual=%0d required=%0d", cyc, t);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        for (int i = 0; i < WORDS; i++) begin
            dut_a.mem_q[i] = 32'hC0DE_0000 + i;
            dut_b.mem_q[i] = 32'hC0DE_0000 + i;
            mem_m[0][i]    = 32'hC0DE_0000 + i;
            mem_m[1][i]    = 32'hC0DE_0000 + i;
        end
        dut_a.mem_q[16] = 32'hDEAD_BEEF;
        mem_m[0][16]    = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        at_cycle(cyc);
        chk("rdy_after_reset", 64'(rdy_a), 64'd1);
        sync();

        // Single read of preloaded word 0x10.
        n0 = cyc;
        send(0, 4'd3, 1'b0, 32'h40, 32'h0);
        idle(0);
        at_cycle(n0 + 4);
        chk("single_rd_early", 64'(rsp_a), 64'd0);
        at_cycle(n0 + 5);
        chk("single_rd", 64'(rsp_a), 64'(mk(1'b1, 4'd3, 1'b0, 32'hDEAD_BEEF)));
        at_cycle(n0 + 6);
        chk("single_rd_late", 64'(rsp_a), 64'd0);
        sync();

        // Write then read the same word on the next cycle.
        n0 = cyc;
        send(0, 4'd1, 1'b1, 32'h8, 32'h1234_5678);
        send(0, 4'd2, 1'b0, 32'h8, 32'h0);
        idle(0);
        at_cycle(n0 + 5);
        chk("wr_rsp", 64'(rsp_a), 64'(mk(1'b1, 4'd1, 1'b1, 32'h1234_5678)));
        at_cycle(n0 + 6);
        chk("rd_after_wr", 64'(rsp_a), 64'(mk(1'b1, 4'd2, 1'b0, 32'h1234_5678)));
        sync();

        // Backpressure: eight held requests against DEPTH=4.
        n0 = cyc;
        fork
            begin
                for (int i = 0; i < 8; i++) send(0, 4'(i), 1'b0, 32'(i * 4), 32'h0);
                idle(0);
            end
            begin
                at_cycle(n0 + 3);
                chk("bp_rdy_n3", 64'(rdy_a), 64'd1);
                at_cycle(n0 + 4);
                chk("bp_rdy_n4", 64'(rdy_a), 64'd0);
                at_cycle(n0 + 5);
                chk("bp_first", 64'(rsp_a), 64'(mk(1'b1, 4'd0, 1'b0, 32'hC0DE_0000)));
            end
        join
        repeat (12) @(posedge clk);
        sync();

        // Full pipeline on DEPTH=LATENCY: 20 back-to-back reads.
        n0 = cyc;
        fork
            begin
                for (int i = 0; i < 20; i++) send(1, 4'(i), 1'b0, 32'(i * 4), 32'h0);
                idle(1);
            end
            begin
                for (int j = 0; j < 20; j++) begin
                    at_cycle(n0 + j);
                    chk("fp_rdy", 64'(rdy_b), 64'd1);
                end
            end
            begin
                for (int j = 0; j < 20; j++) begin
                    at_cycle(n0 + 5 + j);
                    chk("fp_rsp", 64'(rsp_b), 64'(mk(1'b1, 4'(j), 1'b0, 32'hC0DE_0000 + 32'(j))));
                end
                at_cycle(n0 + 25);
                chk("fp_end", 64'(rsp_b.valid), 64'd0);
            end
        join
        sync();

        // Address wrap: 0x1000 aliases word 0.
        n0 = cyc;
        send(0, 4'd5, 1'b1, 32'h1000, 32'hA5A5_A5A5);
        send(0, 4'd6, 1'b0, 32'h0, 32'h0);
        idle(0);
        at_cycle(n0 + 5);
        chk("wrap_wr", 64'(rsp_a), 64'(mk(1'b1, 4'd5, 1'b1, 32'hA5A5_A5A5)));
        at_cycle(n0 + 6);
        chk("wrap_rd", 64'(rsp_a), 64'(mk(1'b1, 4'd6, 1'b0, 32'hA5A5_A5A5)));
        sync();

        // Reset while three reads are in flight.
        n0 = cyc;
        send(0, 4'd9,  1'b0, 32'h40, 32'h0);
        send(0, 4'd10, 1'b0, 32'h44, 32'h0);
        send(0, 4'd11, 1'b0, 32'h48, 32'h0);
        idle(0);
        reset = 1'b1;
        sync();
        sync();
        reset = 1'b0;
        at_cycle(n0 + 5);
        chk("rst_rdy", 64'(rdy_a), 64'd1);
        for (int j = 5; j < 12; j++) begin
            if (j > 5) at_cycle(n0 + j);
            chk("rst_no_rsp", 64'(rsp_a.valid), 64'd0);
        end
        sync();
        n0 = cyc;
        send(0, 4'd12, 1'b0, 32'h40, 32'h0);
        idle(0);
        at_cycle(n0 + 5);
        chk("post_rst_rd", 64'(rsp_a), 64'(mk(1'b1, 4'd12, 1'b0, 32'hDEAD_BEEF)));
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
